alu_seq: RTL

Parametrised, handshaked successor to the team's 4-bit combinational ALU. Adds generic operand width, signed/unsigned compares, shifts and an optional iterative multiplier. Results and flags are registered behind a valid/ready interface. Sits between the operand-select logic and the writeback/display stage of the lab datapath.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_mul_iter.sv | 70 +++++++
 rtl/alu_seq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and flag bundle for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_NOT  = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0011;
   localparam logic [3:0] ALU_OR   = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_EQ   = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1001;
   localparam logic [3:0] ALU_SRL  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1011;
   localparam logic [3:0] ALU_MUL  = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic negative;
      logic illegal;
   } flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/opcode request channel and result/flags response channel of alu_seq.
interface alu_seq_if #(parameter int unsigned WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_func;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_carry;
   logic             out_overflow;
   logic             out_zero;
   logic             out_negative;
   logic             out_illegal;

   modport master (
      output in_valid, in_func, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result,
             out_carry, out_overflow, out_zero, out_negative, out_illegal
   );

   modport slave (
      input  in_valid, in_func, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result,
             out_carry, out_overflow, out_zero, out_negative, out_illegal
   );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Built only when ALU_MUL_EN is defined.
module alu_mul_iter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic             prod_hi_nz
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, step;
   logic [WIDTH-1:0]     mplier_q, mplier_d;

   // The final partial product is folded in combinationally so the
   // product is ready in the same cycle done is raised.
   always_comb begin
      step       = acc_q + (mplier_q[0] ? mcand_q : '0);
      done       = busy_q && (cnt_q == LAST);
      busy       = busy_q;
      prod_lo    = step[WIDTH-1:0];
      prod_hi_nz = |step[2*WIDTH-1:WIDTH];

      cnt_d    = cnt_q;
      busy_d   = busy_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (start) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
      end else if (busy_q) begin
         acc_d    = step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
         if (done) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with optional iterative multiplier.
// ALU_MUL_EN defined: opcode 1100 multiplies; undefined: 1100 is illegal.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);

   localparam int unsigned SHW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d, alu_res;
   flags_t           flags_q, flags_d, alu_fl;
   logic             in_ready, accept, is_mul;
   logic [WIDTH:0]   sum, diff;
   logic [SHW-1:0]   sh;

`ifdef ALU_MUL_EN
   logic             mul_busy, mul_done, mul_hi_nz;
   logic [WIDTH-1:0] mul_lo;

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .start     (accept && is_mul),
      .a         (bus.in_a),
      .b         (bus.in_b),
      .busy      (mul_busy),
      .done      (mul_done),
      .prod_lo   (mul_lo),
      .prod_hi_nz(mul_hi_nz)
   );

   assign is_mul = (bus.in_func == ALU_MUL);
`else
   assign is_mul = 1'b0;
`endif

   assign accept = bus.in_valid && in_ready;

   // Single-cycle datapath
   always_comb begin
      sum     = {1'b0, bus.in_a} + {1'b0, bus.in_b};
      diff    = {1'b0, bus.in_a} - {1'b0, bus.in_b};
      sh      = bus.in_b[SHW-1:0];
      alu_res = '0;
      alu_fl  = '0;
      case (bus.in_func)
         ALU_ADD: begin
            alu_res         = sum[WIDTH-1:0];
            alu_fl.carry    = sum[WIDTH];
            alu_fl.overflow = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &&
                              (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
         end
         ALU_SUB: begin
            alu_res         = diff[WIDTH-1:0];
            alu_fl.carry    = diff[WIDTH];
            alu_fl.overflow = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1]) &&
                              (diff[WIDTH-1] != bus.in_a[WIDTH-1]);
         end
         ALU_NOT:  alu_res = ~bus.in_a;
         ALU_AND:  alu_res = bus.in_a & bus.in_b;
         ALU_OR:   alu_res = bus.in_a | bus.in_b;
         ALU_XOR:  alu_res = bus.in_a ^ bus.in_b;
         ALU_SLTU: alu_res[0] = (bus.in_a < bus.in_b);
         ALU_EQ:   alu_res[0] = (bus.in_a == bus.in_b);
         ALU_SLT:  alu_res[0] = ($signed(bus.in_a) < $signed(bus.in_b));
         ALU_SLL:  alu_res = bus.in_a << sh;
         ALU_SRL:  alu_res = bus.in_a >> sh;
         ALU_SRA:  alu_res = $signed(bus.in_a) >>> sh;
         default:  alu_fl.illegal = 1'b1;
      endcase
      alu_fl.zero     = (alu_res == '0);
      alu_fl.negative = alu_res[WIDTH-1];
   end

   always_comb begin
      res_d   = res_q;
      flags_d = flags_q;
      if (accept && !is_mul) begin
         res_d   = alu_res;
         flags_d = alu_fl;
      end
`ifdef ALU_MUL_EN
      else if (state_q == BUSY && mul_done) begin
         res_d            = mul_lo;
         flags_d          = '0;
         flags_d.carry    = mul_hi_nz;
         flags_d.zero     = (mul_lo == '0);
         flags_d.negative = mul_lo[WIDTH-1];
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         flags_q <= flags_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = is_mul ? BUSY : DONE;
`ifdef ALU_MUL_EN
         BUSY: begin
            if (mul_done)      state_d = DONE;
            else if (!mul_busy) state_d = IDLE;
         end
`else
         BUSY: state_d = IDLE;
`endif
         DONE: begin
            if (bus.out_ready)
               state_d = accept ? (is_mul ? BUSY : DONE) : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready         = !rst && ((state_q == IDLE) ||
                                  (state_q == DONE && bus.out_ready));
      bus.in_ready     = in_ready;
      bus.out_valid    = (state_q == DONE);
      bus.out_result   = res_q;
      bus.out_carry    = flags_q.carry;
      bus.out_overflow = flags_q.overflow;
      bus.out_zero     = flags_q.zero;
      bus.out_negative = flags_q.negative;
      bus.out_illegal  = flags_q.illegal;
   end

endmodule
